msi_cache_ctrl: RTL and testbench
=================================

Name: msi_cache_ctrl

Overview:
Per-processor snoopy MSI cache controller. It is the requester stage directly upstream of the round-robin bus arbiter: it raises bus requests, drives bus message and address during its ownership cycle, and snoops every other cache's transaction. It holds NUM_LINES direct-mapped lines and serves one processor read/write at a time. It writes back Modified data by flush, to memory and to the requesting peer.

Parameters:
NUM_LINES, 2, number of direct-mapped lines (power of 2, ≥2)
ADDR_SIZE, 32, byte address width
CACHE_LINE_SIZE, 128, line width in bits; processor accesses are whole-line

Ports:
clk_i  in  1  clock
rst_i  in  1  reset. Synchronous, active-low.
pr_req_i  in  1  processor request valid; held until pr_ack_o
pr_wr_i  in  1  1 = write, 0 = read
pr_addr_i  in  ADDR_SIZE  processor address
pr_wdata_i  in  CACHE_LINE_SIZE  write data
pr_ack_o  out  1  one-cycle completion pulse
pr_rdata_o  out  CACHE_LINE_SIZE  read data, valid with pr_ack_o
bus_req_o  out  1  bus request to arbiter
bus_gnt_i  in  1  one-cycle grant (this cache's bit of the arbiter one-hot)
bus_msg_o  out  2  00 NONE, 01 BusRd, 10 BusRdX, 11 BusUpgr
bus_addr_o  out  ADDR_SIZE  line address of own transaction
snoop_valid_i  in  1  a transaction is on the bus this cycle
snoop_own_i  in  1  the transaction on the bus is this cache's own
snoop_msg_i  in  2  broadcast message
snoop_addr_i  in  ADDR_SIZE  broadcast address
mem_ack_i  in  1  line fill data valid
mem_data_i  in  CACHE_LINE_SIZE  fill data
flush_o  out  1  one-cycle writeback pulse
flush_addr_o  out  ADDR_SIZE  line address being flushed
flush_data_o  out  CACHE_LINE_SIZE  dirty line data

Behaviour:
- Address split: OFF = log2(CACHE_LINE_SIZE/8). index = addr[OFF +: log2(NUM_LINES)]. Tag is the remaining upper bits. Line addresses have the OFF low bits zeroed.
- Per line: 2-bit state (I=0, S=1, M=2), tag, data.
- Reset (rst_i=0 at a clock edge):
  - all lines set to I
  - FSM set to IDLE
  - all outputs 0
  - any in-flight miss is abandoned
- FSM states:
  - IDLE: with pr_req_i high, a hit needs no bus. A hit is a read on S/M, or a write on M.
    - On a hit, pr_ack_o pulses the next cycle with pr_rdata_o = line data, or with the line written and held in M.
    - Write hit on S → REQ with BusUpgr.
    - Miss with victim in M → EVICT.
    - Any other miss → REQ with BusRd (read) or BusRdX (write).
  - EVICT: flush_o pulses 1 cycle with the victim's address and data. The victim goes to I. Next state is REQ.
  - REQ: bus_req_o=1. bus_msg_o and bus_addr_o are held stable until bus_gnt_i. On the grant cycle, drop bus_req_o.
    - BusUpgr → UPG_DONE.
    - BusRd or BusRdX → FILL.
  - FILL: wait for mem_ack_i, then install tag and mem_data_i.
    - Read: state S, pr_rdata_o = mem_data_i.
    - Write: install pr_wdata_i, state M.
    - pr_ack_o the next cycle; return to IDLE.
  - UPG_DONE: write pr_wdata_i, set the line to M, pulse pr_ack_o, return to IDLE.
- Snoop, evaluated every cycle in every FSM state; ignored when snoop_own_i=1 or the tag mismatches:
  - BusRd on M: flush_o pulses the same cycle; line goes to S.
  - BusRdX on M: flush; line goes to I.
  - BusRdX or BusUpgr on S: line goes to I, no flush.
  - Everything else: no change.
- Upgrade race: in REQ with BusUpgr pending, a snoop invalidating that line switches bus_msg_o to BusRdX before the grant. That transaction then goes to FILL.
- Eviction never collides with a snoop flush: EVICT happens only from IDLE. If a snoop flush hits the same cycle, EVICT stalls one cycle; the snoop flush wins.
- Latency:
  - hit: 1 cycle
  - clean miss: 2 + arbitration wait + memory latency
  - dirty miss: one extra cycle
- pr_req_i is ignored while the FSM is not in IDLE.

Test Plan:
- After reset, read 0x100: BusRd on the grant cycle, addr 0x100; mem_ack_i with data D → pr_ack_o, pr_rdata_o=D, line S.
- Read 0x100 again → pr_ack_o 1 cycle later, no bus_req_o.
- Write 0x100 with W while in S → BusUpgr granted → pr_ack_o, line M. Re-read returns W.
- Line 0x100 in M; snoop BusRd 0x100 → flush_o the same cycle with addr 0x100, data W; line S. A following snoop BusRdX → no flush, line I.
- Line in S, write pending BusUpgr; before grant, snoop BusUpgr 0x100 → bus_msg_o becomes 10 (BusRdX); fill then M.
- Line 0x100 in M; read 0x120 (same index for NUM_LINES=2) → flush_o with 0x100 then BusRd 0x120. Asserting rst_i=0 during FILL → all outputs 0 and the line in I next cycle.

Source files
------------

// File: rtl/msi_cache_ctrl.sv
// Snoopy MSI controller: direct-mapped lines, one processor access at a time, bus requester plus snooper.
// Hit acks next cycle; misses go through optional evict, bus request/grant and memory fill.
module msi_cache_ctrl #(
  parameter int NUM_LINES       = 2,
  parameter int ADDR_SIZE       = 32,
  parameter int CACHE_LINE_SIZE = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pr_req_i,
  input  logic                       pr_wr_i,
  input  logic [ADDR_SIZE-1:0]       pr_addr_i,
  input  logic [CACHE_LINE_SIZE-1:0] pr_wdata_i,
  output logic                       pr_ack_o,
  output logic [CACHE_LINE_SIZE-1:0] pr_rdata_o,
  output logic                       bus_req_o,
  input  logic                       bus_gnt_i,
  output logic [1:0]                 bus_msg_o,
  output logic [ADDR_SIZE-1:0]       bus_addr_o,
  input  logic                       snoop_valid_i,
  input  logic                       snoop_own_i,
  input  logic [1:0]                 snoop_msg_i,
  input  logic [ADDR_SIZE-1:0]       snoop_addr_i,
  input  logic                       mem_ack_i,
  input  logic [CACHE_LINE_SIZE-1:0] mem_data_i,
  output logic                       flush_o,
  output logic [ADDR_SIZE-1:0]       flush_addr_o,
  output logic [CACHE_LINE_SIZE-1:0] flush_data_o
);
  localparam int OFF = $clog2(CACHE_LINE_SIZE / 8);
  localparam int IW  = $clog2(NUM_LINES);
  localparam int TW  = ADDR_SIZE - OFF - IW;

  localparam logic [1:0] L_I = 2'd0, L_S = 2'd1, L_M = 2'd2;
  localparam logic [1:0] MSG_NONE = 2'd0, MSG_RD = 2'd1, MSG_RDX = 2'd2, MSG_UPGR = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_EVICT, ST_REQ, ST_FILL, ST_UPG_DONE} state_t;

  state_t                     r_state, w_next;
  logic [1:0]                 r_lst  [NUM_LINES];
  logic [TW-1:0]              r_tag  [NUM_LINES];
  logic [CACHE_LINE_SIZE-1:0] r_data [NUM_LINES];
  logic [ADDR_SIZE-1:0]       r_addr;
  logic                       r_wr;
  logic [CACHE_LINE_SIZE-1:0] r_wdata, r_rdata;
  logic                       r_ack;
  logic [1:0]                 r_msg, w_msg_nxt;

  logic [IW-1:0] w_pidx, w_ridx, w_sidx;
  logic [TW-1:0] w_ptag, w_rtag, w_stag;
  logic          w_hit, w_accept, w_shit, w_sflush, w_sdown, w_sinv, w_evict_flush, w_upg_kill;
  logic          w_unused_bits;

  assign w_pidx = pr_addr_i[OFF +: IW];
  assign w_ptag = pr_addr_i[ADDR_SIZE-1 -: TW];
  assign w_ridx = r_addr[OFF +: IW];
  assign w_rtag = r_addr[ADDR_SIZE-1 -: TW];
  assign w_sidx = snoop_addr_i[OFF +: IW];
  assign w_stag = snoop_addr_i[ADDR_SIZE-1 -: TW];
  assign w_unused_bits = ^{pr_addr_i[OFF-1:0], snoop_addr_i[OFF-1:0]};

  assign w_shit   = snoop_valid_i && !snoop_own_i && (r_lst[w_sidx] != L_I) && (r_tag[w_sidx] == w_stag);
  assign w_sflush = w_shit && (r_lst[w_sidx] == L_M) && (snoop_msg_i == MSG_RD || snoop_msg_i == MSG_RDX);
  assign w_sdown  = w_shit && (r_lst[w_sidx] == L_M) && (snoop_msg_i == MSG_RD);
  assign w_sinv   = w_shit && (snoop_msg_i == MSG_RDX ||
                               (snoop_msg_i == MSG_UPGR && r_lst[w_sidx] == L_S));

  assign w_hit = (r_tag[w_pidx] == w_ptag) && (r_lst[w_pidx] != L_I) &&
                 (r_lst[w_pidx] == L_M || !pr_wr_i);
  // A snoop touching the requested line this cycle defers acceptance so the snoop update is seen first.
  assign w_accept = (r_state == ST_IDLE) && pr_req_i && !r_ack && !(w_shit && w_sidx == w_pidx);
  assign w_evict_flush = (r_state == ST_EVICT) && !w_sflush && (r_lst[w_ridx] == L_M);
  assign w_upg_kill = (r_state == ST_REQ) && (r_msg == MSG_UPGR) && w_sinv && (w_sidx == w_ridx);

  always_comb begin
    w_next    = r_state;
    w_msg_nxt = r_msg;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_hit) begin
          if (pr_wr_i && r_tag[w_pidx] == w_ptag && r_lst[w_pidx] == L_S) begin
            w_next    = ST_REQ;
            w_msg_nxt = MSG_UPGR;
          end else if (r_lst[w_pidx] == L_M) begin
            w_next = ST_EVICT;
          end else begin
            w_next    = ST_REQ;
            w_msg_nxt = pr_wr_i ? MSG_RDX : MSG_RD;
          end
        end
      end
      ST_EVICT: begin
        if (!w_sflush) begin
          w_next    = ST_REQ;
          w_msg_nxt = r_wr ? MSG_RDX : MSG_RD;
        end
      end
      ST_REQ: begin
        if (bus_gnt_i) begin
          w_next    = (r_msg == MSG_UPGR) ? ST_UPG_DONE : ST_FILL;
          w_msg_nxt = MSG_NONE;
        end else if (w_upg_kill) begin
          w_msg_nxt = MSG_RDX;
        end
      end
      ST_FILL:     if (mem_ack_i) w_next = ST_IDLE;
      ST_UPG_DONE: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_msg   <= MSG_NONE;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_msg   <= w_msg_nxt;
      r_ack   <= 1'b0;
      if (w_accept) begin
        r_addr  <= {pr_addr_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
        r_wr    <= pr_wr_i;
        r_wdata <= pr_wdata_i;
        if (w_hit) begin
          r_ack <= 1'b1;
          if (!pr_wr_i) r_rdata <= r_data[w_pidx];
        end
      end
      if (r_state == ST_FILL && mem_ack_i) begin
        r_ack <= 1'b1;
        if (!r_wr) r_rdata <= mem_data_i;
      end
      if (r_state == ST_UPG_DONE) r_ack <= 1'b1;
    end
  end

  // Snoop updates first; the controller's own install below takes precedence on the same line.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_LINES; i++) r_lst[i] <= L_I;
    end else begin
      if (w_sinv)       r_lst[w_sidx] <= L_I;
      else if (w_sdown) r_lst[w_sidx] <= L_S;
      if (r_state == ST_EVICT && !w_sflush) r_lst[w_ridx] <= L_I;
      if (r_state == ST_FILL && mem_ack_i)  r_lst[w_ridx] <= r_wr ? L_M : L_S;
      if (r_state == ST_UPG_DONE)           r_lst[w_ridx] <= L_M;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept && w_hit && pr_wr_i) r_data[w_pidx] <= pr_wdata_i;
    if (r_state == ST_FILL && mem_ack_i) begin
      r_tag[w_ridx]  <= w_rtag;
      r_data[w_ridx] <= r_wr ? r_wdata : mem_data_i;
    end
    if (r_state == ST_UPG_DONE) r_data[w_ridx] <= r_wdata;
  end

  always_comb begin
    flush_o      = 1'b0;
    flush_addr_o = '0;
    flush_data_o = '0;
    if (w_sflush) begin
      flush_o      = 1'b1;
      flush_addr_o = {snoop_addr_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
      flush_data_o = r_data[w_sidx];
    end else if (w_evict_flush) begin
      flush_o      = 1'b1;
      flush_addr_o = {r_tag[w_ridx], w_ridx, {OFF{1'b0}}};
      flush_data_o = r_data[w_ridx];
    end
  end

  assign pr_ack_o   = r_ack;
  assign pr_rdata_o = r_rdata;
  assign bus_req_o  = (r_state == ST_REQ);
  assign bus_msg_o  = r_msg;
  assign bus_addr_o = (r_state == ST_REQ) ? r_addr : '0;
endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Directed bench for msi_cache_ctrl: miss/hit/upgrade, snoop flushes, upgrade race, eviction and reset mid-fill.
module tb_msi_cache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         pr_req_i, pr_wr_i;
  logic [31:0]  pr_addr_i;
  logic [127:0] pr_wdata_i;
  logic         pr_ack_o;
  logic [127:0] pr_rdata_o;
  logic         bus_req_o, bus_gnt_i;
  logic [1:0]   bus_msg_o;
  logic [31:0]  bus_addr_o;
  logic         snoop_valid_i, snoop_own_i;
  logic [1:0]   snoop_msg_i;
  logic [31:0]  snoop_addr_i;
  logic         mem_ack_i;
  logic [127:0] mem_data_i;
  logic         flush_o;
  logic [31:0]  flush_addr_o;
  logic [127:0] flush_data_o;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] D  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] W  = 128'hA5A5_A5A5_0123_4567_89AB_CDEF_5A5A_5A5A;
  localparam logic [127:0] D2 = 128'h1357_9BDF_2468_ACE0_FFFF_0000_1234_5678;
  localparam logic [127:0] W2 = 128'hCAFE_F00D_8765_4321_0F0F_F0F0_AAAA_5555;
  localparam logic [127:0] JUNK = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  msi_cache_ctrl #(.NUM_LINES(2), .ADDR_SIZE(32), .CACHE_LINE_SIZE(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pr_req_i(pr_req_i), .pr_wr_i(pr_wr_i), .pr_addr_i(pr_addr_i), .pr_wdata_i(pr_wdata_i),
    .pr_ack_o(pr_ack_o), .pr_rdata_o(pr_rdata_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_msg_o(bus_msg_o), .bus_addr_o(bus_addr_o),
    .snoop_valid_i(snoop_valid_i), .snoop_own_i(snoop_own_i), .snoop_msg_i(snoop_msg_i),
    .snoop_addr_i(snoop_addr_i),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .flush_o(flush_o), .flush_addr_o(flush_addr_o), .flush_data_o(flush_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic snoop(input logic own, input logic [1:0] msg, input logic [31:0] a);
    snoop_valid_i = 1'b1;
    snoop_own_i   = own;
    snoop_msg_i   = msg;
    snoop_addr_i  = a;
    #1;
  endtask

  task automatic snoop_off;
    snoop_valid_i = 1'b0;
    snoop_own_i   = 1'b0;
    snoop_msg_i   = 2'd0;
    snoop_addr_i  = '0;
  endtask

  // Clean read miss with immediate grant; ends with the line in S and the request dropped.
  task automatic read_miss(input logic [31:0] a, input logic [127:0] d);
    pr_req_i = 1'b1; pr_wr_i = 1'b0; pr_addr_i = a;
    tick;
    check("rm_req", bus_req_o, 1);
    check("rm_msg", bus_msg_o, 2'b01);
    check("rm_addr", bus_addr_o, a);
    bus_gnt_i = 1'b1;
    tick;
    bus_gnt_i = 1'b0;
    check("rm_req_drop", bus_req_o, 0);
    mem_ack_i = 1'b1; mem_data_i = d;
    tick;
    mem_ack_i = 1'b0;
    check("rm_ack", pr_ack_o, 1);
    check("rm_rdata", pr_rdata_o, d);
    pr_req_i = 1'b0;
    tick;
    check("rm_ack_pulse", pr_ack_o, 0);
    check("rm_state_S", dut.r_lst[0], 2'd1);
  endtask

  task automatic read_hit(input logic [31:0] a, input logic [127:0] d);
    pr_req_i = 1'b1; pr_wr_i = 1'b0; pr_addr_i = a;
    tick;
    check("rh_ack", pr_ack_o, 1);
    check("rh_rdata", pr_rdata_o, d);
    check("rh_nobus", bus_req_o, 0);
    pr_req_i = 1'b0;
    tick;
    check("rh_ack_pulse", pr_ack_o, 0);
  endtask

  initial begin
    rst_i = 1'b0;
    pr_req_i = 1'b0; pr_wr_i = 1'b0; pr_addr_i = '0; pr_wdata_i = '0;
    bus_gnt_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
    snoop_off();
    tick; tick;
    check("rst_ack", pr_ack_o, 0);
    check("rst_req", bus_req_o, 0);
    check("rst_msg", bus_msg_o, 0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_rdata", pr_rdata_o, 0);
    rst_i = 1'b1;
    tick;

    read_miss(32'h100, D);
    read_hit(32'h100, D);

    // Write hit on S: upgrade, held one cycle before grant
    pr_req_i = 1'b1; pr_wr_i = 1'b1; pr_addr_i = 32'h100; pr_wdata_i = W;
    tick;
    check("up_req", bus_req_o, 1);
    check("up_msg", bus_msg_o, 2'b11);
    tick;
    check("up_msg_hold", bus_msg_o, 2'b11);
    check("up_addr_hold", bus_addr_o, 32'h100);
    bus_gnt_i = 1'b1;
    tick;
    bus_gnt_i = 1'b0;
    check("up_req_drop", bus_req_o, 0);
    check("up_no_early_ack", pr_ack_o, 0);
    tick;
    check("up_ack", pr_ack_o, 1);
    check("up_state_M", dut.r_lst[0], 2'd2);
    pr_req_i = 1'b0;
    tick;
    read_hit(32'h100, W);

    // Own transaction is never snooped
    snoop(1'b1, 2'b10, 32'h100);
    check("own_noflush", flush_o, 0);
    tick;
    snoop_off();
    check("own_keep_M", dut.r_lst[0], 2'd2);

    snoop(1'b0, 2'b01, 32'h100);
    check("srd_flush", flush_o, 1);
    check("srd_faddr", flush_addr_o, 32'h100);
    check("srd_fdata", flush_data_o, W);
    tick;
    snoop_off();
    check("srd_state_S", dut.r_lst[0], 2'd1);
    snoop(1'b0, 2'b10, 32'h108);
    check("srdx_noflush", flush_o, 0);
    tick;
    snoop_off();
    check("srdx_state_I", dut.r_lst[0], 2'd0);

    // Upgrade race: a peer BusUpgr kills the S copy before our grant
    read_miss(32'h100, D2);
    pr_req_i = 1'b1; pr_wr_i = 1'b1; pr_addr_i = 32'h100; pr_wdata_i = W2;
    tick;
    check("race_msg_up", bus_msg_o, 2'b11);
    snoop(1'b0, 2'b11, 32'h100);
    tick;
    snoop_off();
    check("race_msg_rdx", bus_msg_o, 2'b10);
    check("race_req", bus_req_o, 1);
    check("race_state_I", dut.r_lst[0], 2'd0);
    bus_gnt_i = 1'b1;
    tick;
    bus_gnt_i = 1'b0;
    mem_ack_i = 1'b1; mem_data_i = JUNK;
    tick;
    mem_ack_i = 1'b0;
    check("race_ack", pr_ack_o, 1);
    check("race_state_M", dut.r_lst[0], 2'd2);
    pr_req_i = 1'b0;
    tick;
    read_hit(32'h100, W2);

    // Dirty conflict miss: evict 0x100, then BusRd 0x120, reset mid-fill
    pr_req_i = 1'b1; pr_wr_i = 1'b0; pr_addr_i = 32'h120;
    tick;
    check("ev_flush", flush_o, 1);
    check("ev_faddr", flush_addr_o, 32'h100);
    check("ev_fdata", flush_data_o, W2);
    check("ev_nobus", bus_req_o, 0);
    tick;
    check("ev_flush_pulse", flush_o, 0);
    check("ev_state_I", dut.r_lst[0], 2'd0);
    check("ev_req", bus_req_o, 1);
    check("ev_msg", bus_msg_o, 2'b01);
    check("ev_addr", bus_addr_o, 32'h120);
    bus_gnt_i = 1'b1;
    tick;
    bus_gnt_i = 1'b0;
    rst_i = 1'b0;
    tick;
    check("fr_ack", pr_ack_o, 0);
    check("fr_req", bus_req_o, 0);
    check("fr_msg", bus_msg_o, 0);
    check("fr_addr", bus_addr_o, 0);
    check("fr_rdata", pr_rdata_o, 0);
    check("fr_flush", flush_o, 0);
    check("fr_state_I", dut.r_lst[0], 2'd0);
    rst_i = 1'b1;
    pr_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_data_i = D;
    tick;
    mem_ack_i = 1'b0;
    tick;
    check("fr_abandoned", pr_ack_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
